// File: rtl/max_window_reducer_if.sv
// rtl/max_window_reducer_if.sv - sample-in / result-out handshake bundle for max_window_reducer
interface max_window_reducer_if #(
  parameter int D_W   = 32,
  parameter int CNT_W = 3
);
  logic             in_valid;
  logic             in_ready;
  logic [D_W-1:0]   in_data;
  logic             in_flush;
  logic             out_valid;
  logic             out_ready;
  logic [D_W-1:0]   out_data;
  logic [CNT_W-1:0] out_idx;

  // Reducer side: takes samples, offers results
  modport slave (
    input  in_valid, in_data, in_flush, out_ready,
    output in_ready, out_valid, out_data, out_idx
  );

  // Environment side: sample source and result consumer
  modport master (
    output in_valid, in_data, in_flush, out_ready,
    input  in_ready, out_valid, out_data, out_idx
  );
endinterface

// File: rtl/max_window_reducer.sv
// rtl/max_window_reducer.sv - windowed signed-max reducer; define MAX_WIN_ARGMAX_EN to report the argmax on out_idx
module max_window_reducer #(
  parameter int D_W     = 32,
  parameter int WIN_LEN = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  max_window_reducer_if.slave bus
);
  localparam int               CNT_W = (WIN_LEN > 1) ? $clog2(WIN_LEN) : 1;
  localparam logic [CNT_W-1:0] LAST  = CNT_W'(WIN_LEN - 1);

  logic [CNT_W-1:0]      cnt;
  logic signed [D_W-1:0] acc;
  logic signed [D_W-1:0] sample;
  logic signed [D_W-1:0] new_max;
  logic [D_W-1:0]        out_data_q;
  logic                  out_valid_q;
  logic                  in_ready;
  logic                  is_first;
  logic                  is_last;
  logic                  improve;
  logic                  accept;
  logic                  complete;

  assign sample   = $signed(bus.in_data);
  assign is_first = (cnt == '0);
  assign is_last  = (cnt == LAST);
  assign improve  = (sample > acc);

  // Only the window-closing sample can collide with an untaken result; a
  // same-cycle consumer handshake frees the register, so ready follows out_ready.
  assign in_ready = !(is_last && out_valid_q && !bus.out_ready);

  // A flushed sample is still handshaken but never enters the window.
  assign accept   = bus.in_valid && in_ready && !bus.in_flush;
  assign complete = accept && is_last;

  // Strict compare: equal values keep the earlier sample.
  assign new_max  = (is_first || improve) ? sample : acc;

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Window position and running max; flush wins over a same-cycle sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      acc <= '0;
    end else if (bus.in_flush) begin
      cnt <= '0;
    end else if (accept) begin
      acc <= new_max;
      cnt <= is_last ? '0 : cnt + 1'b1;
    end
  end

  // Result register: load on completion, otherwise drop valid once taken
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else if (complete) begin
      out_valid_q <= 1'b1;
      out_data_q  <= new_max;
    end else if (out_valid_q && bus.out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

`ifdef MAX_WIN_ARGMAX_EN
  logic [CNT_W-1:0] idx;
  logic [CNT_W-1:0] new_idx;
  logic [CNT_W-1:0] out_idx_q;

  assign new_idx     = (is_first || improve) ? cnt : idx;
  assign bus.out_idx = out_idx_q;

  // Position of the running max, moved only on strict improvement
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx <= '0;
    end else if (accept) begin
      idx <= new_idx;
    end
  end

  // Argmax travels with the result it belongs to
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_idx_q <= '0;
    end else if (complete) begin
      out_idx_q <= new_idx;
    end
  end
`else
  assign bus.out_idx = '0;
`endif
endmodule

// File: tb/tb_max_window_reducer.sv
// tb/tb_max_window_reducer.sv - self-checking bench for max_window_reducer (WIN_LEN 4 and 1)
module tb_max_window_reducer;
`ifdef MAX_WIN_ARGMAX_EN
  localparam bit ARGMAX_EN = 1'b1;
`else
  localparam bit ARGMAX_EN = 1'b0;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad   = 0;

  max_window_reducer_if #(.D_W(32), .CNT_W(2)) i4 ();
  max_window_reducer_if #(.D_W(32), .CNT_W(1)) i1 ();

  max_window_reducer #(.D_W(32), .WIN_LEN(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(i4.slave));
  max_window_reducer #(.D_W(32), .WIN_LEN(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(i1.slave));

  always #5 clk = ~clk;

  // Set inputs just after a rising edge, then move to the falling edge to observe
  task automatic drive4(input logic v, input int d, input logic f, input logic r);
    i4.in_valid  = v;
    i4.in_data   = d;
    i4.in_flush  = f;
    i4.out_ready = r;
    @(negedge clk);
  endtask

  task automatic drive1(input logic v, input int d, input logic r);
    i1.in_valid  = v;
    i1.in_data   = d;
    i1.in_flush  = 1'b0;
    i1.out_ready = r;
    @(negedge clk);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    drive4(0, 0, 0, 0);
    drive1(0, 0, 0);
    apply_reset();
    total++; if (i4.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid4 got=%b want=0", i4.out_valid); end
    total++; if (i4.out_data !== 32'd0) begin bad++; $display("FAIL reset_data4 got=%0d want=0", $signed(i4.out_data)); end
    total++; if (i4.out_idx !== 2'd0) begin bad++; $display("FAIL reset_idx4 got=%0d want=0", i4.out_idx); end
    total++; if (i4.in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready4 got=%b want=1", i4.in_ready); end
    total++; if (i1.out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid1 got=%b want=0", i1.out_valid); end
  endtask

  task automatic test_basic();
    int seq[4] = '{3, -7, 9, 2};
    for (int k = 0; k < 4; k++) begin
      drive4(1, seq[k], 0, 1);
      total++; if (i4.out_valid !== 1'b0) begin bad++; $display("FAIL basic_early_valid k=%0d got=%b want=0", k, i4.out_valid); end
      next_cycle();
    end
    total++; if (i4.out_valid !== 1'b1) begin bad++; $display("FAIL basic_valid got=%b want=1", i4.out_valid); end
    total++; if ($signed(i4.out_data) !== 9) begin bad++; $display("FAIL basic_data got=%0d want=9", $signed(i4.out_data)); end
    total++; if (i4.out_idx !== (ARGMAX_EN ? 2'd2 : 2'd0)) begin bad++; $display("FAIL basic_idx got=%0d want=%0d", i4.out_idx, ARGMAX_EN ? 2 : 0); end
    drive4(0, 0, 0, 1);
    next_cycle();
    total++; if (i4.out_valid !== 1'b0) begin bad++; $display("FAIL basic_drop got=%b want=0", i4.out_valid); end
    total++; if ($signed(i4.out_data) !== 9) begin bad++; $display("FAIL basic_hold got=%0d want=9", $signed(i4.out_data)); end
  endtask

  task automatic test_negative_tie();
    int seq[4] = '{-5, -2, -9, -2};
    for (int k = 0; k < 4; k++) begin
      drive4(1, seq[k], 0, 1);
      next_cycle();
    end
    total++; if (i4.out_valid !== 1'b1) begin bad++; $display("FAIL neg_valid got=%b want=1", i4.out_valid); end
    total++; if ($signed(i4.out_data) !== -2) begin bad++; $display("FAIL neg_data got=%0d want=-2", $signed(i4.out_data)); end
    total++; if (i4.out_idx !== (ARGMAX_EN ? 2'd1 : 2'd0)) begin bad++; $display("FAIL neg_idx got=%0d want=%0d", i4.out_idx, ARGMAX_EN ? 1 : 0); end
    drive4(0, 0, 0, 1);
    next_cycle();
  endtask

  task automatic test_backpressure();
    for (int k = 1; k <= 7; k++) begin
      drive4(1, k, 0, 0);
      total++; if (i4.in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready k=%0d got=%b want=1", k, i4.in_ready); end
      next_cycle();
      if (k == 4) begin
        total++; if ($signed(i4.out_data) !== 4) begin bad++; $display("FAIL bp_first got=%0d want=4", $signed(i4.out_data)); end
      end
    end
    for (int k = 0; k < 3; k++) begin
      drive4(1, 8, 0, 0);
      total++; if (i4.in_ready !== 1'b0) begin bad++; $display("FAIL bp_stall k=%0d got=%b want=0", k, i4.in_ready); end
      next_cycle();
      total++; if (i4.out_valid !== 1'b1 || $signed(i4.out_data) !== 4) begin bad++; $display("FAIL bp_stable k=%0d got=%b/%0d want=1/4", k, i4.out_valid, $signed(i4.out_data)); end
    end
    drive4(1, 8, 0, 1);
    total++; if (i4.in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%b want=1", i4.in_ready); end
    total++; if ($signed(i4.out_data) !== 4) begin bad++; $display("FAIL bp_deliver1 got=%0d want=4", $signed(i4.out_data)); end
    next_cycle();
    total++; if (i4.out_valid !== 1'b1 || $signed(i4.out_data) !== 8) begin bad++; $display("FAIL bp_deliver2 got=%b/%0d want=1/8", i4.out_valid, $signed(i4.out_data)); end
    drive4(0, 0, 0, 1);
    next_cycle();
    total++; if (i4.out_valid !== 1'b0) begin bad++; $display("FAIL bp_drain got=%b want=0", i4.out_valid); end
  endtask

  task automatic test_flush();
    int seq[7] = '{10, 20, 99, 1, 2, 3, 4};
    for (int k = 0; k < 7; k++) begin
      drive4(1, seq[k], (k == 2), 1);
      next_cycle();
      if (k < 6) begin
        total++; if (i4.out_valid !== 1'b0) begin bad++; $display("FAIL flush_early k=%0d got=%b want=0 data=%0d", k, i4.out_valid, $signed(i4.out_data)); end
      end
    end
    total++; if (i4.out_valid !== 1'b1 || $signed(i4.out_data) !== 4) begin bad++; $display("FAIL flush_result got=%b/%0d want=1/4", i4.out_valid, $signed(i4.out_data)); end
    drive4(0, 0, 0, 1);
    next_cycle();
  endtask

  task automatic test_mid_reset();
    int seq[6] = '{5, 6, 7, 8, 1, 2};
    int win[4] = '{3, -4, 11, 0};
    for (int k = 0; k < 6; k++) begin
      drive4(1, seq[k], 0, 0);
      next_cycle();
    end
    total++; if (i4.out_valid !== 1'b1 || $signed(i4.out_data) !== 8) begin bad++; $display("FAIL rst_pending got=%b/%0d want=1/8", i4.out_valid, $signed(i4.out_data)); end
    drive4(0, 0, 0, 0);
    rst_n = 1'b0;
    #1;
    total++; if (i4.out_valid !== 1'b0 || i4.out_data !== 32'd0) begin bad++; $display("FAIL rst_async got=%b/%0d want=0/0", i4.out_valid, $signed(i4.out_data)); end
    @(posedge clk);
    #1 rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      drive4(1, win[k], 0, 1);
      next_cycle();
      if (k < 3) begin
        total++; if (i4.out_valid !== 1'b0) begin bad++; $display("FAIL rst_early k=%0d got=%b want=0", k, i4.out_valid); end
      end
    end
    total++; if (i4.out_valid !== 1'b1 || $signed(i4.out_data) !== 11) begin bad++; $display("FAIL rst_result got=%b/%0d want=1/11", i4.out_valid, $signed(i4.out_data)); end
    total++; if (i4.out_idx !== (ARGMAX_EN ? 2'd2 : 2'd0)) begin bad++; $display("FAIL rst_idx got=%0d want=%0d", i4.out_idx, ARGMAX_EN ? 2 : 0); end
    drive4(0, 0, 0, 1);
    next_cycle();
  endtask

  task automatic test_win1();
    int seq[3] = '{5, -1, 7};
    for (int k = 0; k < 3; k++) begin
      drive1(1, seq[k], 1);
      total++; if (i1.in_ready !== 1'b1) begin bad++; $display("FAIL w1_ready k=%0d got=%b want=1", k, i1.in_ready); end
      next_cycle();
      total++; if (i1.out_valid !== 1'b1 || $signed(i1.out_data) !== seq[k]) begin bad++; $display("FAIL w1_data k=%0d got=%b/%0d want=1/%0d", k, i1.out_valid, $signed(i1.out_data), seq[k]); end
      total++; if (i1.out_idx !== 1'b0) begin bad++; $display("FAIL w1_idx k=%0d got=%0d want=0", k, i1.out_idx); end
    end
    drive1(0, 0, 1);
    next_cycle();
    total++; if (i1.out_valid !== 1'b0) begin bad++; $display("FAIL w1_drain got=%b want=0", i1.out_valid); end
  endtask

  // Reference: collect samples into a window list, reduce when it holds four
  task automatic test_random();
    int   win_q[$];
    int   exp_d[$];
    int   exp_i[$];
    logic v = 1'b0;
    int   d = 0;
    logic f;
    logic r;
    logic exp_rdy;
    logic took = 1'b1;
    int   m;
    int   mi;
    apply_reset();
    for (int c = 0; c < 1500; c++) begin
      if (!v || took) begin
        v = ($urandom_range(0, 3) != 0);
        d = ($urandom_range(0, 4) == 0) ? int'($urandom) : int'($urandom_range(0, 12)) - 6;
      end
      f = ($urandom_range(0, 19) == 0);
      r = ($urandom_range(0, 2) != 0);
      drive4(v, d, f, r);
      exp_rdy = !(win_q.size() == 3 && exp_d.size() != 0 && !r);
      total++; if (i4.in_ready !== exp_rdy) begin bad++; $display("FAIL rnd_ready c=%0d got=%b want=%b", c, i4.in_ready, exp_rdy); end
      total++; if (i4.out_valid !== (exp_d.size() != 0)) begin bad++; $display("FAIL rnd_valid c=%0d got=%b want=%b", c, i4.out_valid, exp_d.size() != 0); end
      if (exp_d.size() != 0) begin
        total++; if ($signed(i4.out_data) !== exp_d[0]) begin bad++; $display("FAIL rnd_data c=%0d got=%0d want=%0d", c, $signed(i4.out_data), exp_d[0]); end
        total++; if (i4.out_idx !== 2'(ARGMAX_EN ? exp_i[0] : 0)) begin bad++; $display("FAIL rnd_idx c=%0d got=%0d want=%0d", c, i4.out_idx, ARGMAX_EN ? exp_i[0] : 0); end
      end
      if (exp_d.size() != 0 && r) begin
        void'(exp_d.pop_front());
        void'(exp_i.pop_front());
      end
      took = v && exp_rdy;
      if (f) begin
        win_q.delete();
      end else if (took) begin
        win_q.push_back(d);
        if (win_q.size() == 4) begin
          m  = win_q[0];
          mi = 0;
          for (int k = 1; k < 4; k++) begin
            if (win_q[k] > m) begin
              m  = win_q[k];
              mi = k;
            end
          end
          exp_d.push_back(m);
          exp_i.push_back(mi);
          win_q.delete();
        end
      end
      next_cycle();
    end
  endtask

  initial begin
    i4.in_valid = 1'b0; i4.in_data = '0; i4.in_flush = 1'b0; i4.out_ready = 1'b0;
    i1.in_valid = 1'b0; i1.in_data = '0; i1.in_flush = 1'b0; i1.out_ready = 1'b0;
    test_reset();
    test_basic();
    test_negative_tie();
    test_backpressure();
    test_flush();
    test_mid_reset();
    test_win1();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
